dmem_scratchpad_ctrl: RTL and testbench
=======================================

Name: dmem_scratchpad_ctrl

Overview:
- Data scratchpad memory controller, directly downstream of the load/store unit's single memory port.
- Accepts one word-sized read or write request at a time, models a fixed access latency, and returns a one-cycle ready pulse with read data or an error flag.
- Owns the data scratchpad array, a bench/boot preload port, and access statistics counters.

Parameters:
- XLEN, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the scratchpad (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4-aligned).
- ACCESS_LAT, 2, cycles from request acceptance to mem_ready (legal values 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  in  1  request valid; held high by the LSU until mem_ready is sampled.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  XLEN  byte address.
- mem_wdata  in  XLEN  store data.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  XLEN  read data; valid only while mem_ready=1, otherwise 0.
- mem_error  out  1  error qualifier; valid only while mem_ready=1, otherwise 0.
- init_we  in  1  preload write enable.
- init_addr  in  $clog2(DEPTH_WORDS)  preload word index.
- init_wdata  in  XLEN  preload data.
- rd_count  out  32  completed error-free reads.
- wr_count  out  32  completed error-free writes.
- err_count  out  32  completed erroring requests.

Behaviour:
- Reset, synchronous:
  - State goes to IDLE.
  - mem_ready, mem_error, mem_rdata, and all counters go to 0.
  - Any in-flight request is discarded; a pending write is never performed.
  - Array contents are not reset.
- FSM states:
  - IDLE: if mem_req=1, latch we, addr, wdata and the error decode, and load the latency counter with ACCESS_LAT-1. Go to RESP if ACCESS_LAT=1, else BUSY.
  - BUSY: decrement the counter; go to RESP when the counter reaches 0. Input changes are ignored, including mem_req dropping; the request still completes.
  - RESP: mem_ready=1 for exactly one cycle, then return to IDLE.
- Requests are accepted only in IDLE, so at most one is outstanding.
- Latency: a request sampled in IDLE in cycle 0 gives mem_ready=1 in cycle ACCESS_LAT.
- Turnaround: the LSU deasserts mem_req the cycle after mem_ready, so a new request is accepted no earlier than cycle ACCESS_LAT+1. Minimum spacing between accepts is ACCESS_LAT+1 cycles.
- Error decode, computed on the latched address; error if any of:
  - addr[1:0] != 0;
  - addr < BASE_ADDR;
  - addr >= BASE_ADDR + DEPTH_WORDS*4;
  - addr[31:28] == 4'hF (MMIO space is not served here).
- Word index = (addr - BASE_ADDR) >> 2, truncated to the index width.
- Array update, at the edge that enters RESP:
  - Error-free write: array[index] <= wdata.
  - Error-free read: mem_rdata register <= array[index]. This includes the effect of any init write made at an earlier edge.
  - Erroring request: no array write; mem_rdata = 0, mem_error = 1.
  - Writes return mem_rdata = 0.
- Counters:
  - Exactly one of rd_count / wr_count / err_count increments at the RESP edge.
  - Counters wrap at 2^32.
- Preload port:
  - init_we writes array[init_addr] on any edge, in any state, including during reset.
  - If init_we targets the same word as an LSU write committing on the same edge, the LSU write wins.
  - A read committing on that edge returns the old value.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset hold then release → mem_ready=0, mem_error=0, mem_rdata=0, and all counters 0 for 3 cycles with mem_req=0.
- init_we writes word 5 = 32'hCAFE_F00D; read addr 0x14 with ACCESS_LAT=2 accepted in cycle 0 → mem_ready=1 only in cycle 2, mem_rdata=32'hCAFE_F00D, mem_error=0, rd_count=1.
- Write 0x40 ← 32'h1234_5678, then a read of 0x40 issued the cycle after ready → read returns 32'h1234_5678; wr_count=1, rd_count=1; the two accepts are 3 cycles apart.
- Read 0x42 (misaligned), read BASE_ADDR+DEPTH_WORDS*4 (out of range), read 0xF000_0000 (MMIO) → each completes with mem_error=1 and mem_rdata=0; err_count=3; array unchanged.
- Write 0x80 ← 32'hAAAA_AAAA, with reset asserted in cycle 1 of BUSY → no ready pulse; a subsequent read of 0x80 returns the prior contents; wr_count=0.
- LSU write to word 8 (32'h1) on the same edge as init_we to word 8 (32'h2) → a later read returns 32'h1. Repeat with ACCESS_LAT=1 → ready in the cycle after accept.

Source files
------------

// File: rtl/dmem_scratchpad_ctrl_if.sv
// LSU-to-scratchpad memory port bundle: request/write data in, ready/read data/error back.
// The master side holds mem_req until it samples mem_ready; the slave side pulses mem_ready once per request.
// The slave side is never stalled by the master.
interface dmem_scratchpad_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_error;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_error
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_error
    );
endinterface

// File: rtl/dmem_scratchpad_ctrl.sv
// Data scratchpad controller: one outstanding word read/write, preload port, access statistics.
// Latency: request accepted in IDLE in cycle 0 gives a one-cycle mem_ready pulse in cycle ACCESS_LAT.
// Backpressure: requests are taken only in IDLE; mem_req is simply not sampled while a request is in flight.
module dmem_scratchpad_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              ACCESS_LAT  = 2,
    localparam int             IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_scratchpad_ctrl_if.slave bus,
    input  logic                 init_we,
    input  logic [IDX_W-1:0]     init_addr,
    input  logic [XLEN-1:0]      init_wdata,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count,
    output logic [31:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   commit;

    logic [3:0]      lat_cnt;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            cur_we;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [XLEN:0]   off;
    logic            req_err;
    logic [IDX_W-1:0] idx;

    logic [XLEN-1:0] mem_array [DEPTH_WORDS];

    logic            ready_q;
    logic            error_q;
    logic [XLEN-1:0] rdata_q;

    // With ACCESS_LAT=1 the commit edge is the accept edge, so the live inputs stand in for the latches.
    assign cur_we    = (state == IDLE) ? bus.mem_we    : we_q;
    assign cur_addr  = (state == IDLE) ? bus.mem_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;

    // The extra top bit of the offset is the borrow, i.e. the address sits below BASE_ADDR.
    assign off     = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign req_err = off[XLEN]
                   | (|off[XLEN-1:IDX_W+2])
                   | (|off[1:0])
                   | (cur_addr[XLEN-1 -: 4] == 4'hF);
    assign idx     = off[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    accept    = 1'b1;
                    state_nxt = (ACCESS_LAT == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (lat_cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = !reset && (state_nxt == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.mem_we;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
                lat_cnt <= 4'(ACCESS_LAT - 1);
            end else if (state == BUSY) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            ready_q <= commit;
            error_q <= commit && req_err;
            rdata_q <= (commit && !req_err && !cur_we) ? mem_array[idx] : '0;
            if (commit) begin
                if (req_err)     err_count <= err_count + 32'd1;
                else if (cur_we) wr_count  <= wr_count + 32'd1;
                else             rd_count  <= rd_count + 32'd1;
            end
        end
    end

    // Preload runs regardless of reset; the later LSU assignment wins a same-word collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_array[init_addr] <= init_wdata;
        end
        if (commit && cur_we && !req_err) begin
            mem_array[idx] <= cur_wdata;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_error = error_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_scratchpad_ctrl.sv
// Two scratchpad controllers (ACCESS_LAT 2 and 1) sharing reset and preload, checked against an array model.
module tb_dmem_scratchpad_ctrl;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        init_we = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [31:0] init_wdata = '0;
    int          sel = 0;

    logic [31:0] rd0, wr0, er0, rd1, wr1, er1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][DEPTH];
    int unsigned m_rd [2];
    int unsigned m_wr [2];
    int unsigned m_er [2];

    always #5 clk = ~clk;

    dmem_scratchpad_ctrl_if #(.XLEN(32)) bus0 ();
    dmem_scratchpad_ctrl_if #(.XLEN(32)) bus1 ();

    assign bus0.mem_req   = req && (sel == 0);
    assign bus0.mem_we    = we;
    assign bus0.mem_addr  = addr;
    assign bus0.mem_wdata = wdata;
    assign bus1.mem_req   = req && (sel == 1);
    assign bus1.mem_we    = we;
    assign bus1.mem_addr  = addr;
    assign bus1.mem_wdata = wdata;

    dmem_scratchpad_ctrl #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .ACCESS_LAT(LAT0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .rd_count(rd0), .wr_count(wr0), .err_count(er0)
    );

    dmem_scratchpad_ctrl #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .ACCESS_LAT(LAT1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
        .rd_count(rd1), .wr_count(wr1), .err_count(er1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a);
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, BASE};
        return (a % 4 != 0) || (ua < ub) || (ua >= ub + 4 * DEPTH) || (a >= 32'hF000_0000);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4) % DEPTH;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check_counts(input string tag, input int s);
        check({tag, "_rd"},  (s == 0) ? rd0 : rd1, m_rd[s]);
        check({tag, "_wr"},  (s == 0) ? wr0 : wr1, m_wr[s]);
        check({tag, "_err"}, (s == 0) ? er0 : er1, m_er[s]);
    endtask

    task automatic init_write(input int i, input logic [31:0] d);
        @(negedge clk);
        init_we    = 1'b1;
        init_addr  = 10'(i);
        init_wdata = d;
        @(posedge clk);
        #1;
        init_we = 1'b0;
        mdl[0][i] = d;
        mdl[1][i] = d;
    endtask

    // One LSU request; coll drives a preload of cd to the same word on the commit edge.
    task automatic do_req(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit coll, input logic [31:0] cd);
        int          n;
        bit          seen;
        bit          e;
        int          ix;
        logic [31:0] exp_rd;
        int          lat;
        lat = lat_of(s);
        @(negedge clk);
        check("ready_idle", 32'({bus1.mem_ready, bus0.mem_ready}), 32'h0);
        sel        = s;
        req        = 1'b1;
        we         = w;
        addr       = a;
        wdata      = d;
        init_we    = coll && (lat == 1);
        init_addr  = a[11:2];
        init_wdata = cd;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            n = i;
            if (((s == 0) ? bus0.mem_ready : bus1.mem_ready) === 1'b1) seen = 1'b1;
            init_we = coll && !seen && (i == lat - 1);
        end
        req     = 1'b0;
        init_we = 1'b0;

        e  = model_err(a);
        ix = model_idx(a);
        exp_rd = '0;
        if (!e && !w) exp_rd = mdl[s][ix];
        if (coll) begin
            mdl[0][ix] = cd;
            mdl[1][ix] = cd;
        end
        if (e)      m_er[s]++;
        else if (w) begin
            m_wr[s]++;
            mdl[s][ix] = d;
        end else    m_rd[s]++;

        check("ready_seen", 32'(seen), 32'h1);
        check("latency", n, lat);
        check("error", 32'((s == 0) ? bus0.mem_error : bus1.mem_error), 32'(e));
        check("rdata", (s == 0) ? bus0.mem_rdata : bus1.mem_rdata, exp_rd);
        check_counts("cnt", s);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        int          cls;
        int          s;
        bit          w;
        bit          coll;

        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 0;
            m_wr[k] = 0;
            m_er[k] = 0;
        end

        // Preload every word while reset is held.
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) init_write(i, $urandom);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", 32'({bus1.mem_ready, bus0.mem_ready}), 32'h0);
            check("rst_error", 32'({bus1.mem_error, bus0.mem_error}), 32'h0);
            check("rst_rdata", bus0.mem_rdata | bus1.mem_rdata, 32'h0);
            check_counts("rst0", 0);
            check_counts("rst1", 1);
        end

        init_write(5, 32'hCAFE_F00D);
        do_req(0, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0);

        do_req(0, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);

        do_req(0, 1'b0, 32'h42, 32'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, BASE + DEPTH * 4, 32'h0, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'hF000_0000, 32'h0, 1'b0, 32'h0);
        do_req(0, 1'b1, 32'h43, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);

        // Reset lands on the edge that would commit the write.
        @(negedge clk);
        sel = 0; req = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 0;
            m_wr[k] = 0;
            m_er[k] = 0;
        end
        check("busy_rst_ready", 32'(bus0.mem_ready), 32'h0);
        check_counts("busy_rst", 0);
        repeat (3) begin
            @(negedge clk);
            check("busy_rst_quiet", 32'(bus0.mem_ready), 32'h0);
        end
        do_req(0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);

        do_req(0, 1'b1, 32'h20, 32'h1, 1'b1, 32'h2);
        do_req(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        do_req(1, 1'b1, 32'h20, 32'h1, 1'b1, 32'h2);
        do_req(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        do_req(1, 1'b0, 32'h24, 32'h0, 1'b1, 32'h5555_0000);
        do_req(1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0);

        for (int it = 0; it < 80; it++) begin
            s    = int'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            cls  = int'($urandom_range(0, 5));
            rd   = $urandom;
            coll = 1'b0;
            case (cls)
                3:       ra = {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
                4:       ra = $urandom_range(BASE + DEPTH * 4, 32'hEFFF_FFFF) & ~32'h3;
                5:       ra = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
                default: begin
                    ra   = BASE + {$urandom_range(0, DEPTH - 1), 2'b00};
                    coll = ($urandom_range(0, 3) == 0);
                end
            endcase
            if ($urandom_range(0, 4) == 0) init_write(int'($urandom_range(0, DEPTH - 1)), $urandom);
            do_req(s, w, ra, rd, coll, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
